// File: rtl/vga_timing_pkg.sv
// Shared raster timing types, the 640x480@60 presets and the axis total helper.
package vga_timing_pkg;

   typedef struct packed {
      int unsigned active;
      int unsigned fp;
      int unsigned sync;
      int unsigned bp;
   } timing_t;

   localparam timing_t VGA_640X480_H = '{active: 640, fp: 16, sync: 96, bp: 48};
   localparam timing_t VGA_640X480_V = '{active: 480, fp: 10, sync: 2, bp: 33};

   function automatic int unsigned total(timing_t t);
      return t.active + t.fp + t.sync + t.bp;
   endfunction

endpackage

// File: rtl/vga_timing_gen_sync_axis_counter.sv
// One raster axis: wrapping position counter with advance enable and
// in-sync / in-active / at-zero decode of the current count.
module sync_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int unsigned ACTIVE = 640,
   parameter int unsigned FP     = 16,
   parameter int unsigned SYNC   = 96,
   parameter int unsigned BP     = 48,
   parameter int unsigned W      = $clog2(ACTIVE + FP + SYNC + BP)
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         adv_i,
   output logic [W-1:0] cnt_o,
   output logic         wrap_o,
   output logic         sync_o,
   output logic         active_o,
   output logic         zero_o
);

   localparam int unsigned TOTAL = total(timing_t'{ACTIVE, FP, SYNC, BP});
   localparam int unsigned S_LO  = ACTIVE + FP;
   localparam int unsigned S_HI  = ACTIVE + FP + SYNC;

   logic [W-1:0] cnt_q, cnt_d;
   logic [31:0]  cnt32;

   // Compare in 32 bits so sync/total bounds equal to 2^W do not alias.
   assign cnt32    = 32'(cnt_q);
   assign wrap_o   = (cnt32 == TOTAL - 1);
   assign sync_o   = (cnt32 >= S_LO) && (cnt32 < S_HI);
   assign active_o = (cnt32 < ACTIVE);
   assign zero_o   = (cnt_q == '0);
   assign cnt_o    = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (adv_i) begin
         cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with pixel clock-enable.
// Define VGA_TIMING_FRAME_CNT_EN to add the o_frame_cnt frame counter.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE = VGA_640X480_H.active,
   parameter int unsigned H_FP     = VGA_640X480_H.fp,
   parameter int unsigned H_SYNC   = VGA_640X480_H.sync,
   parameter int unsigned H_BP     = VGA_640X480_H.bp,
   parameter int unsigned V_ACTIVE = VGA_640X480_V.active,
   parameter int unsigned V_FP     = VGA_640X480_V.fp,
   parameter int unsigned V_SYNC   = VGA_640X480_V.sync,
   parameter int unsigned V_BP     = VGA_640X480_V.bp,
   parameter bit          H_POL    = 1'b0,
   parameter bit          V_POL    = 1'b0,
   parameter int unsigned XW       = 10,
   parameter int unsigned YW       = 9
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_ce,
   output logic          o_hsync,
   output logic          o_vsync,
   output logic          o_active_video,
   output logic [XW-1:0] o_x_pos,
   output logic [YW-1:0] o_y_pos,
   output logic          o_line_start,
   output logic          o_frame_start,
`ifdef VGA_TIMING_FRAME_CNT_EN
   output logic          o_vblank_start,
   output logic [15:0]   o_frame_cnt
`else
   output logic          o_vblank_start
`endif
);

   localparam int unsigned HW = $clog2(total(timing_t'{H_ACTIVE, H_FP, H_SYNC, H_BP}));
   localparam int unsigned VW = $clog2(total(timing_t'{V_ACTIVE, V_FP, V_SYNC, V_BP}));

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic h_wrap, h_sync, h_act, h_zero;
   logic v_sync, v_act, v_zero;

   sync_axis_counter #(
      .ACTIVE (H_ACTIVE), .FP (H_FP), .SYNC (H_SYNC), .BP (H_BP), .W (HW)
   ) u_h (
      .clk_i    (i_clk),
      .rst_i    (i_rst),
      .adv_i    (i_ce),
      .cnt_o    (h_cnt),
      .wrap_o   (h_wrap),
      .sync_o   (h_sync),
      .active_o (h_act),
      .zero_o   (h_zero)
   );

   sync_axis_counter #(
      .ACTIVE (V_ACTIVE), .FP (V_FP), .SYNC (V_SYNC), .BP (V_BP), .W (VW)
   ) u_v (
      .clk_i    (i_clk),
      .rst_i    (i_rst),
      .adv_i    (i_ce & h_wrap),
      .cnt_o    (v_cnt),
      .wrap_o   (),
      .sync_o   (v_sync),
      .active_o (v_act),
      .zero_o   (v_zero)
   );

   logic          hs_q, hs_d, vs_q, vs_d, act_q, act_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic          line_q, line_d, frame_q, frame_d, vbl_q, vbl_d;

   // Levels hold between pixel enables; strobes drop on any idle clock.
   always_comb begin
      hs_d    = hs_q;
      vs_d    = vs_q;
      act_d   = act_q;
      x_d     = x_q;
      y_d     = y_q;
      line_d  = 1'b0;
      frame_d = 1'b0;
      vbl_d   = 1'b0;
      if (i_ce) begin
         hs_d    = h_sync ? H_POL : ~H_POL;
         vs_d    = v_sync ? V_POL : ~V_POL;
         act_d   = h_act & v_act;
         x_d     = (h_act & v_act) ? XW'(h_cnt) : '0;
         y_d     = (h_act & v_act) ? YW'(v_cnt) : '0;
         line_d  = h_zero;
         frame_d = h_zero & v_zero;
         vbl_d   = h_zero & (32'(v_cnt) == V_ACTIVE);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         hs_q    <= ~H_POL;
         vs_q    <= ~V_POL;
         act_q   <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         line_q  <= 1'b0;
         frame_q <= 1'b0;
         vbl_q   <= 1'b0;
      end else begin
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         act_q   <= act_d;
         x_q     <= x_d;
         y_q     <= y_d;
         line_q  <= line_d;
         frame_q <= frame_d;
         vbl_q   <= vbl_d;
      end
   end

   assign o_hsync        = hs_q;
   assign o_vsync        = vs_q;
   assign o_active_video = act_q;
   assign o_x_pos        = x_q;
   assign o_y_pos        = y_q;
   assign o_line_start   = line_q;
   assign o_frame_start  = frame_q;
   assign o_vblank_start = vbl_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [15:0] fcnt_q, fcnt_d;
   logic        fseen_q, fseen_d;

   // The first frame after reset keeps count 0; later frame starts bump it.
   always_comb begin
      fcnt_d  = fcnt_q;
      fseen_d = fseen_q;
      if (frame_d) begin
         fseen_d = 1'b1;
         if (fseen_q) fcnt_d = fcnt_q + 16'd1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         fcnt_q  <= '0;
         fseen_q <= 1'b0;
      end else begin
         fcnt_q  <= fcnt_d;
         fseen_q <= fseen_d;
      end
   end

   assign o_frame_cnt = fcnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised-enable bench for vga_timing_gen on a small 14x7 raster,
// checked against a pixel-index model of the raster.
module tb_vga_timing_gen;

   localparam int HA = 8, HF = 2, HS = 2, HB = 2;
   localparam int VA = 4, VF = 1, VS = 1, VB = 1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam bit HP = 1'b1, VP = 1'b1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ce  = 1'b0;
   logic       hs, vs, act, ls, fs, vbs;
   logic [2:0] x;
   logic [1:0] y;
   logic [15:0] fcnt;

   int n_chk  = 0;
   int n_fail = 0;
   int n_ce   = 0;
   bit strobe = 1'b0;

   always #5 clk = ~clk;

   vga_timing_gen #(
      .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
      .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
      .H_POL (HP), .V_POL (VP), .XW (3), .YW (2)
   ) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_ce           (ce),
      .o_hsync        (hs),
      .o_vsync        (vs),
      .o_active_video (act),
      .o_x_pos        (x),
      .o_y_pos        (y),
      .o_line_start   (ls),
      .o_frame_start  (fs),
`ifdef VGA_TIMING_FRAME_CNT_EN
      .o_vblank_start (vbs),
      .o_frame_cnt    (fcnt)
`else
      .o_vblank_start (vbs)
`endif
   );

`ifndef VGA_TIMING_FRAME_CNT_EN
   assign fcnt = '0;
`endif

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Pixel p is the p-th enabled edge since reset; raster is row-major.
   task automatic compare();
      int p, h, v, e_act;
      if (n_ce == 0) begin
         check("hsync", hs, !HP);
         check("vsync", vs, !VP);
         check("active", act, 0);
         check("x", x, 0);
         check("y", y, 0);
         check("line", ls, 0);
         check("frame", fs, 0);
         check("vblank", vbs, 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
         check("fcnt", fcnt, 0);
`endif
      end else begin
         p = n_ce - 1;
         h = p % HT;
         v = (p / HT) % VT;
         e_act = (h < HA && v < VA) ? 1 : 0;
         check("hsync", hs, (h >= HA + HF && h < HA + HF + HS) ? HP : !HP);
         check("vsync", vs, (v >= VA + VF && v < VA + VF + VS) ? VP : !VP);
         check("active", act, e_act);
         check("x", x, e_act ? h : 0);
         check("y", y, e_act ? v : 0);
         check("line", ls, strobe && h == 0);
         check("frame", fs, strobe && h == 0 && v == 0);
         check("vblank", vbs, strobe && h == 0 && v == VA);
`ifdef VGA_TIMING_FRAME_CNT_EN
         check("fcnt", fcnt, (p / (HT * VT)) % 65536);
`endif
      end
   endtask

   task automatic step(input bit r, input bit c);
      @(negedge clk);
      rst = r;
      ce  = c;
      @(posedge clk);
      if (r) begin
         n_ce   = 0;
         strobe = 1'b0;
      end else if (c) begin
         n_ce++;
         strobe = 1'b1;
      end else begin
         strobe = 1'b0;
      end
      #1;
      compare();
   endtask

   initial begin
      for (int i = 0; i < 3; i++) step(1'b1, 1'(i));
      for (int i = 0; i < 3 * HT * VT + 5; i++) step(1'b0, 1'b1);
      for (int i = 0; i < 2 * HT * VT; i++) step(1'b0, 1'(i % 2 == 0));
      while (n_ce == 0 || (n_ce - 1) % (HT * VT) != 5 * HT + 10)
         step(1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom_range(1)));
      for (int i = 0; i < 2 * HT * VT; i++) step(1'b0, 1'b1);
      for (int i = 0; i < 3000; i++)
         step($urandom_range(299) == 0, $urandom_range(3) != 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised raster timing generator, successor to the fixed 640x480@60 sync generator.
- Produces hsync/vsync, the active-video flag, pixel coordinates, and line/frame/vblank event strobes for the FFT spectrum display path.
- Timing, sync polarity and coordinate widths are set by parameters.
- A pixel clock-enable lets it run from a faster system clock, e.g. 50 MHz with i_ce at 1/2 rate.
- All outputs are registered and mutually aligned.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, hsync asserted level (0 = active-low)
- V_POL, 0, vsync asserted level (0 = active-low)
- XW, 10, o_x_pos width; must satisfy 2^XW >= H_ACTIVE
- YW, 9, o_y_pos width; must satisfy 2^YW >= V_ACTIVE

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- i_ce  in  1  pixel enable; counters advance only when high
- o_hsync  out  1  horizontal sync at H_POL level while asserted
- o_vsync  out  1  vertical sync at V_POL level while asserted
- o_active_video  out  1  high inside the H_ACTIVE x V_ACTIVE region
- o_x_pos  out  XW  pixel column; 0 outside the active region
- o_y_pos  out  YW  pixel row; 0 outside the active region
- o_line_start  out  1  one-clock strobe at h==0 of every line, blanking lines included
- o_frame_start  out  1  one-clock strobe at h==0, v==0
- o_vblank_start  out  1  one-clock strobe at h==0, v==V_ACTIVE (safe FFT buffer swap point)

Behaviour:
- Derived values: H_TOTAL = sum of the H_* parameters (800 by default); V_TOTAL = sum of the V_* parameters (525 by default).
- h counter width is clog2(H_TOTAL); v counter width is clog2(V_TOTAL).
- Counter advance, only on i_clk edges with i_ce=1:
  - h wraps H_TOTAL-1 -> 0.
  - v increments only when h wraps, and wraps V_TOTAL-1 -> 0.
- Output decode from the current (h, v), registered on the same i_ce edge:
  - hsync asserted iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vsync asserted iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, on whole lines.
  - active iff h<H_ACTIVE and v<V_ACTIVE.
  - x = h and y = v when active, else 0.
- Latency: outputs show counter state (h, v) one i_clk after the i_ce edge that produced that state. All outputs always refer to the same (h, v); no cross-output skew.
- Strobes:
  - Set on the i_ce edge that registers the qualifying (h, v).
  - Forced low on every i_clk edge with i_ce=0, so each is exactly one i_clk wide regardless of the i_ce rate.
- Level outputs (sync, active, x, y) hold their value while i_ce=0.
- Reset, which overrides i_ce:
  - h=0, v=0.
  - o_hsync=~H_POL, o_vsync=~V_POL.
  - o_active_video=0, o_x_pos=0, o_y_pos=0, all strobes 0.
- First i_ce edge after reset registers (0,0): active=1 and o_frame_start, o_line_start pulse.
- Reset mid-frame: restart at (0,0) on the next clock; no partial sync pulse is extended.
- i_ce held high: 1 pixel per clock, same cadence as the legacy generator.

Optional Feature:
- Macro: VGA_TIMING_FRAME_CNT_EN.
- Defined:
  - Adds output o_frame_cnt [15:0].
  - Reset to 0; increments on the same edge that asserts o_frame_start, except the first frame after reset, which reads 0.
  - Wraps 65535 -> 0.
- Undefined: the port and the counter do not exist.

Decomposition:
- Package vga_timing_pkg holds:
  - typedef struct timing_t {active, fp, sync, bp} for one axis.
  - Constants VGA_640X480_H and VGA_640X480_V.
  - Function total(timing_t).
- One natural sub-module, sync_axis_counter, instantiated twice (horizontal and vertical). It provides the wrapping counter with advance enable and the in-sync / in-active / at-zero decode.

Test Plan:
- Defaults, i_ce=1: hsync low for exactly 96 clocks, period 800; vsync low for exactly 1600 clocks, period 420000; o_frame_start every 420000 clocks.
- Defaults: x=639, y=479 seen with active=1; next clock x=0, y=0, active=0; o_vblank_start pulses once per frame, 384000 clocks after o_frame_start.
- i_ce toggling 1,0,1,0: all periods double (hsync low 192 clocks); every strobe still exactly 1 clock wide; x/y hold while i_ce=0.
- Small config H=8/2/2/2, V=4/1/1/1, H_POL=V_POL=1: line 14 pixels, frame 7 lines = 98 ce-cycles; hsync high at h=10..11; vsync high on v=5.
- Assert i_rst for 3 clocks at (h=700, v=300): outputs hold reset values during reset; first ce after release gives x=0, y=0, active=1, frame_start=1.
- With VGA_TIMING_FRAME_CNT_EN: o_frame_cnt reads 0, 1, 2 across three consecutive frames after reset.
